// File: rtl/mul32_iter_if.sv
// Request/result bundle for the iterative multiplier: operands and start in; busy, done and HI/LO out.
interface mul32_iter_if;
  logic        start;
  logic        Sign;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, Sign, A, B, input busy, done, HI, LO);
  modport slave  (input start, Sign, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/mul32_iter.sv
// Iterative 32x32 shift-add multiplier, signed/unsigned, 64-bit HI/LO result; start ignored while busy.
// Latency 34 cycles start->done; with MUL_EARLY_EXIT_EN defined it drops to 3 + msb index of |B|.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        sign,
  output logic [31:0] sum,
  output logic        v
);
  logic [32:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
  assign sum  = full[31:0];
  // Signed overflow when sign=1, unsigned carry-out when sign=0
  assign v    = sign ? ((a[31] == b[31]) && (sum[31] != a[31])) : full[32];
endmodule

module mul32_iter (
  input logic         clk,
  input logic         reset,
  mul32_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [63:0] acc_sum;
  logic [31:0] mult;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  cnt;
  logic        neg;
  logic        busy_q;
  logic        done_q;
  logic        lo_carry;
  logic        hi_carry;
  logic        last_step;

  assign mag_a = (bus.Sign && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
  assign mag_b = (bus.Sign && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;

  adder32 u_add_lo (
    .a    (acc[31:0]),
    .b    (mcand[31:0]),
    .cin  (1'b0),
    .sign (1'b0),
    .sum  (acc_sum[31:0]),
    .v    (lo_carry)
  );

  adder32 u_add_hi (
    .a    (acc[63:32]),
    .b    (mcand[63:32]),
    .cin  (lo_carry),
    .sign (1'b0),
    .sum  (acc_sum[63:32]),
    .v    (hi_carry)
  );

`ifdef MUL_EARLY_EXIT_EN
  // Leave once the bits still to be consumed are all zero; the current bit is added this cycle
  assign last_step = (cnt == 6'd31) || (mult[31:1] == 31'd0);
`else
  assign last_step = (cnt == 6'd31);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mult   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            acc    <= '0;
            mcand  <= {32'b0, mag_a};
            mult   <= mag_b;
            cnt    <= '0;
            neg    <= bus.Sign & (bus.A[31] ^ bus.B[31]);
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mult[0]) acc <= acc_sum;
          mcand <= {mcand[62:0], 1'b0};
          mult  <= {1'b0, mult[31:1]};
          cnt   <= cnt + 6'd1;
          if (last_step) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= neg ? (~acc + 64'd1) : acc;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Partial sums of two 32-bit magnitudes always fit in 64 bits
  assert property (@(posedge clk) disable iff (!reset) (state == CALC && mult[0]) |-> !hi_carry);

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi;
  assign bus.LO   = lo;
endmodule
